sha_mem_arbiter: RTL and testbench
==================================

SHA_MEM_ARBITER -- requirements
Module: sha_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 8, number of SHA-core requesters (2..16).
REQ-002 SHALL have parameter RD_LAT, default 1, memory read latency in cycles from mem_addr driven to mem_read_data valid (1..4).
REQ-003 SHALL have port clk  input  1  clock; all state on posedge clk.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  arbitration enable; low = no new grants.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester access request.
REQ-007 SHALL have port lock  input  NUM_REQ  per-requester burst lock, keeps priority on the granted requester.
REQ-008 SHALL have port we  input  NUM_REQ  per-requester write flag (1 = write, 0 = read).
REQ-009 SHALL have port addr  input  NUM_REQ*16  packed per-requester word address, requester i at bits [16i+15:16i].
REQ-010 SHALL have port wdata  input  NUM_REQ*32  packed per-requester write data, same packing as addr.
REQ-011 SHALL have port gnt  output  NUM_REQ  one-hot combinational grant.
REQ-012 SHALL have port rvalid  output  NUM_REQ  one-hot read-return strobe.
REQ-013 SHALL have port rdata  output  32  read data broadcast to all requesters.
REQ-014 SHALL have port busy  output  1  high while any read is in flight or any req is high.
REQ-015 SHALL have ports mem_we (output, 1), mem_addr (output, 16), mem_write_data (output, 32), mem_read_data (input, 32): shared memory port.

Function
REQ-016 SHALL assert at most one gnt bit per cycle, and only when en=1 and the matching req bit is 1.
REQ-017 SHALL select the first requesting index at or above rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-018 SHALL accept a transfer at the posedge where req[i] & gnt[i]; the requester holds req/we/addr/wdata stable until then.
REQ-019 SHALL update rr_ptr on each accept: to i when lock[i]=1, otherwise to (i+1) mod NUM_REQ.
REQ-020 SHALL hold rr_ptr when no accept occurs.
REQ-021 SHALL register mem_addr, mem_we and mem_write_data from the accepted requester, valid the cycle after accept.
REQ-022 SHALL drive mem_we=1 for exactly one cycle per accepted write, and mem_we=0 in every cycle with no accepted write.
REQ-023 SHALL leave mem_addr and mem_write_data unchanged in cycles with no accept.
REQ-024 SHALL track each accepted read in a RD_LAT-deep tag pipeline holding {valid, requester id}.
REQ-025 SHALL assert rvalid[id] for one cycle exactly RD_LAT cycles after mem_addr is driven for that read (accept + 1 + RD_LAT), with rdata = mem_read_data in that cycle.
REQ-026 SHALL drive rdata combinationally from mem_read_data and drive rvalid=0 when no tagged read returns.
REQ-027 SHALL support back-to-back accepts every cycle with mixed reads and writes, with no lost or reordered returns.
REQ-028 SHALL let in-flight reads still return normally after en is deasserted.
REQ-029 SHALL drop a req that is deasserted before it is granted, with no side effect.

Reset
REQ-030 SHALL on reset_n low set rr_ptr=0, clear all tag-pipeline valid bits, and set mem_we=0, mem_addr=0, mem_write_data=0 and rvalid=0.
REQ-031 SHALL never return data to a requester for a read issued before a mid-operation reset.
REQ-032 SHALL force gnt=0 while reset_n is low.

Structure
REQ-033 SHALL take ADDR_W=16, DATA_W=32 and the requester-id type (width $clog2(NUM_REQ)) from shared package sha_arb_pkg.
REQ-034 SHALL place the combinational rotate-priority selection in sub-module rr_picker (inputs req and ptr; outputs one-hot grant and encoded id).

Verification
REQ-035 SHALL cover reset then req=8'hFF, lock=0, en=1 -> grants in order 0,1,...,7,0, one per cycle, rr_ptr wraps.
REQ-036 SHALL cover req[3] write addr=16'h0010 wdata=32'hDEADBEEF -> gnt[3] same cycle; next cycle mem_we=1, mem_addr=16'h0010, mem_write_data=32'hDEADBEEF; mem_we=0 the cycle after.
REQ-037 SHALL cover, with RD_LAT=1, req[5] read addr 16'h0004 and memory returning 32'h12345678 -> rvalid=8'h20 and rdata=32'h12345678 exactly 2 cycles after accept.
REQ-038 SHALL cover req[2] with lock[2]=1 for 16 reads while req[6] is pending -> 16 consecutive grants to 2; the first grant after lock drops goes to 6.
REQ-039 SHALL cover 3 reads accepted on consecutive cycles then reset_n pulsed low -> no rvalid after reset, mem_we=0, next grant goes to index 0.
REQ-040 SHALL cover en dropped one cycle after a read accept -> gnt=0 while en=0, and the in-flight rvalid still fires on schedule.

Source files
------------

// File: rtl/sha_arb_pkg.sv
// Shared widths and helpers for the SHA-core memory arbiter.
// The requester id is sized from the requester count with req_id_w().
package sha_arb_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int DEF_NUM_REQ = 8;

    // Requester id width; never narrower than one bit.
    function automatic int req_id_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    typedef logic [req_id_w(DEF_NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority pick: the first requesting index at or above ptr wins,
// with the search wrapping from N-1 back to 0.
module rr_picker #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] id
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among SHA cores, with lockable
// bursts and a tag pipeline that routes read data back to the issuing core.
module sha_mem_arbiter
    import sha_arb_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_write_data,
    input  logic [DATA_W-1:0]         mem_read_data
);

    localparam int ID_W = req_id_w(NUM_REQ);
    typedef logic [ID_W-1:0] id_t;

    id_t                rr_ptr_q, rr_ptr_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               issue_vld_q, issue_vld_d;
    id_t                issue_id_q, issue_id_d;
    logic [RD_LAT-1:0]  tag_vld_q, tag_vld_d;
    id_t                tag_id_q [RD_LAT];
    id_t                tag_id_d [RD_LAT];

    logic [NUM_REQ-1:0] pick_gnt;
    id_t                pick_id;
    logic               accept;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_picker (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .id  (pick_id)
    );

    // The picker only grants requesting indices, so any grant is an accept.
    assign gnt    = (reset_n && en) ? pick_gnt : '0;
    assign accept = |gnt;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        issue_vld_d = 1'b0;
        issue_id_d  = issue_id_q;
        if (accept) begin
            mem_we_d    = we[pick_id];
            mem_addr_d  = addr[int'(pick_id)*ADDR_W +: ADDR_W];
            mem_wdata_d = wdata[int'(pick_id)*DATA_W +: DATA_W];
            issue_vld_d = ~we[pick_id];
            issue_id_d  = pick_id;
            if (lock[pick_id]) begin
                rr_ptr_d = pick_id;
            end else if (pick_id == id_t'(NUM_REQ-1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = pick_id + id_t'(1);
            end
        end
    end

    // Stage 0 follows the cycle mem_addr is driven; the last stage lines up
    // with mem_read_data for that read.
    always_comb begin
        tag_vld_d    = '0;
        tag_vld_d[0] = issue_vld_q;
        for (int s = 0; s < RD_LAT; s++) begin
            tag_id_d[s] = '0;
        end
        tag_id_d[0] = issue_id_q;
        for (int s = 1; s < RD_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            issue_vld_q <= 1'b0;
            issue_id_q  <= '0;
            tag_vld_q   <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            issue_vld_q <= issue_vld_d;
            issue_id_q  <= issue_id_d;
            tag_vld_q   <= tag_vld_d;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (tag_vld_q[RD_LAT-1]) begin
            rvalid[tag_id_q[RD_LAT-1]] = 1'b1;
        end
    end

    assign rdata          = mem_read_data;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign busy           = (|req) | issue_vld_q | (|tag_vld_q);

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Directed bench for sha_mem_arbiter: stimulus queues expected grants, a
// negedge monitor pops them and checks memory writes and read returns.
module tb_sha_mem_arbiter;

    localparam int N      = 8;
    localparam int RD_LAT = 1;

    logic            clk;
    logic            reset_n;
    logic            en;
    logic [N-1:0]    req, lock, we, gnt, rvalid;
    logic [N*16-1:0] addr;
    logic [N*32-1:0] wdata;
    logic [31:0]     rdata, mem_write_data, mem_read_data;
    logic            busy, mem_we;
    logic [15:0]     mem_addr;

    sha_mem_arbiter #(.NUM_REQ(N), .RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .en             (en),
        .req            (req),
        .lock           (lock),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .busy           (busy),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input logic [7:0] a);
        if (a == 8'h04) return 32'h12345678;
        return {8'hA5, a, ~a, 8'h5A};
    endfunction

    // Memory model with one cycle of read latency.
    logic [31:0]  ram [256];
    logic [255:0] ram_wr = '0;
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[7:0]]    <= mem_write_data;
            ram_wr[mem_addr[7:0]] <= 1'b1;
        end
        mem_read_data <= ram_wr[mem_addr[7:0]] ? ram[mem_addr[7:0]] : pat(mem_addr[7:0]);
    end

    typedef struct { int id; logic w; logic [15:0] a; logic [31:0] d; } gexp_t;
    typedef struct { logic [15:0] a; logic [31:0] d; int due; } wexp_t;
    typedef struct { int id; logic [31:0] d; int due; } rexp_t;

    gexp_t exp_g [$];
    wexp_t exp_w [$];
    rexp_t exp_r [$];

    logic [31:0]  shadow [256];
    logic [255:0] shadow_wr = '0;

    gexp_t m_g;
    wexp_t m_w;
    rexp_t m_r;

    always @(negedge clk) begin
        if (reset_n) begin
            if (gnt != 0) begin
                chk("gnt_subset_of_req", {24'b0, gnt & ~req}, 32'h0);
                if (exp_g.size() == 0) begin
                    chk("unexpected_gnt", {24'b0, gnt}, 32'h0);
                end else begin
                    m_g = exp_g.pop_front();
                    chk("gnt_order", {24'b0, gnt}, 32'(1) << m_g.id);
                    if (m_g.w) begin
                        shadow[m_g.a[7:0]]    = m_g.d;
                        shadow_wr[m_g.a[7:0]] = 1'b1;
                        exp_w.push_back('{a: m_g.a, d: m_g.d, due: cyc + 1});
                    end else begin
                        exp_r.push_back('{id: m_g.id,
                                          d: shadow_wr[m_g.a[7:0]] ? shadow[m_g.a[7:0]] : pat(m_g.a[7:0]),
                                          due: cyc + 1 + RD_LAT});
                    end
                end
            end
            if (mem_we) begin
                if (exp_w.size() == 0) begin
                    chk("spurious_mem_we", {31'b0, mem_we}, 32'h0);
                end else begin
                    m_w = exp_w.pop_front();
                    chk("mem_we_cycle", cyc, m_w.due);
                    chk("mem_addr", {16'b0, mem_addr}, {16'b0, m_w.a});
                    chk("mem_write_data", mem_write_data, m_w.d);
                end
            end else if (exp_w.size() != 0 && exp_w[0].due <= cyc) begin
                chk("missing_mem_we", {31'b0, mem_we}, 32'h1);
                void'(exp_w.pop_front());
            end
            if (rvalid != 0) begin
                if (exp_r.size() == 0) begin
                    chk("spurious_rvalid", {24'b0, rvalid}, 32'h0);
                end else begin
                    m_r = exp_r.pop_front();
                    chk("rvalid_cycle", cyc, m_r.due);
                    chk("rvalid_id", {24'b0, rvalid}, 32'(1) << m_r.id);
                    chk("rdata", rdata, m_r.d);
                end
            end else if (exp_r.size() != 0 && exp_r[0].due <= cyc) begin
                chk("missing_rvalid", {24'b0, rvalid}, 32'(1) << exp_r[0].id);
                void'(exp_r.pop_front());
            end
        end
    end

    task automatic set_req(input int i, input logic w, input logic [15:0] a, input logic [31:0] d);
        req[i]          = 1'b1;
        we[i]           = w;
        addr[i*16 +: 16] = a;
        wdata[i*32 +: 32] = d;
        exp_g.push_back('{id: i, w: w, a: a, d: d});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        en      = 1'b1;
        req     = '0;
        lock    = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;

        // Reset state, with all requests high to prove gnt is forced low.
        req = 8'hFF;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {24'b0, gnt}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_write_data, 32'h0);
        chk("rst_rvalid", {24'b0, rvalid}, 32'h0);
        req = '0;

        // Full round robin with mixed reads and writes, then wrap to 0.
        for (int i = 0; i < N; i++) begin
            set_req(i, (i % 2) == 1, 16'h0020 + 16'(i), 32'hC0DE0000 + 32'(i));
        end
        nxt();
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("rr_order", {24'b0, gnt}, 32'(1) << k);
            nxt();
            req[k] = 1'b0;
            if (k == N - 1) set_req(0, 1'b0, 16'h0020, 32'h0);
        end
        @(negedge clk);
        chk("rr_wrap", {24'b0, gnt}, 32'h1);
        nxt();
        req = '0;
        we  = '0;
        repeat (4) nxt();

        // Locked burst on 2 while 6 waits (pointer is at 1 here).
        lock[2] = 1'b1;
        for (int k = 0; k < 16; k++) set_req(2, 1'b0, 16'h0030, 32'h0);
        set_req(6, 1'b0, 16'h0031, 32'h0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("lock_burst", {24'b0, gnt}, 32'h04);
            nxt();
            if (k == 15) begin
                req[2]  = 1'b0;
                lock[2] = 1'b0;
            end
        end
        @(negedge clk);
        chk("after_lock", {24'b0, gnt}, 32'h40);
        nxt();
        req = '0;
        repeat (4) nxt();

        // Single write from requester 3.
        set_req(3, 1'b1, 16'h0010, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_gnt", {24'b0, gnt}, 32'h08);
        nxt();
        req = '0;
        @(negedge clk);
        chk("wr_mem_we", {31'b0, mem_we}, 32'h1);
        chk("wr_mem_addr", {16'b0, mem_addr}, 32'h0010);
        chk("wr_mem_wdata", mem_write_data, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_mem_we_off", {31'b0, mem_we}, 32'h0);
        chk("wr_addr_held", {16'b0, mem_addr}, 32'h0010);
        we = '0;
        repeat (3) nxt();

        // Single read from requester 5, returning two cycles after accept.
        set_req(5, 1'b0, 16'h0004, 32'h0);
        @(negedge clk);
        chk("rd_gnt", {24'b0, gnt}, 32'h20);
        nxt();
        req = '0;
        @(negedge clk);
        chk("rd_no_early_rvalid", {24'b0, rvalid}, 32'h0);
        @(negedge clk);
        chk("rd_rvalid", {24'b0, rvalid}, 32'h20);
        chk("rd_rdata", rdata, 32'h12345678);
        repeat (3) nxt();

        // en dropped the cycle after a read accept; the return still fires.
        set_req(1, 1'b0, 16'h0040, 32'h0);
        @(negedge clk);
        chk("en_rd_gnt", {24'b0, gnt}, 32'h02);
        nxt();
        req = '0;
        nxt();
        en = 1'b0;
        set_req(7, 1'b0, 16'h0041, 32'h0);
        @(negedge clk);
        chk("en_off_gnt", {24'b0, gnt}, 32'h0);
        chk("en_off_rvalid", {24'b0, rvalid}, 32'h02);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("en_off_gnt", {24'b0, gnt}, 32'h0);
        end
        nxt();
        en = 1'b1;
        @(negedge clk);
        chk("en_on_gnt", {24'b0, gnt}, 32'h80);
        nxt();
        req = '0;
        repeat (4) nxt();

        // Three back-to-back reads, then reset before the last two return.
        for (int i = 2; i <= 4; i++) set_req(i, 1'b0, 16'h0050 + 16'(i), 32'h0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("pre_rst_gnt", {24'b0, gnt}, 32'(1) << k);
            nxt();
            req[k] = 1'b0;
        end
        reset_n = 1'b0;
        exp_g.delete();
        exp_w.delete();
        exp_r.delete();
        req = 8'h81;
        @(negedge clk);
        chk("in_rst_gnt", {24'b0, gnt}, 32'h0);
        chk("in_rst_rvalid", {24'b0, rvalid}, 32'h0);
        req = '0;
        nxt();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_rvalid", {24'b0, rvalid}, 32'h0);
            chk("post_rst_mem_we", {31'b0, mem_we}, 32'h0);
        end
        nxt();
        set_req(0, 1'b0, 16'h0060, 32'h0);
        set_req(7, 1'b0, 16'h0067, 32'h0);
        @(negedge clk);
        chk("post_rst_first_gnt", {24'b0, gnt}, 32'h01);
        nxt();
        req[0] = 1'b0;
        @(negedge clk);
        chk("post_rst_second_gnt", {24'b0, gnt}, 32'h80);
        nxt();
        req = '0;
        repeat (6) nxt();

        @(negedge clk);
        chk("busy_idle", {31'b0, busy}, 32'h0);
        chk("exp_gnt_left", exp_g.size(), 32'h0);
        chk("exp_wr_left", exp_w.size(), 32'h0);
        chk("exp_rd_left", exp_r.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
